// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N one-hot decoder with minterm mask and scan mode (optional DOWN_SCAN_EN adds dir)
module scan_decoder #(
   parameter int                 N         = 3,
   parameter int                 DWELL     = 1,
   parameter logic [(1<<N)-1:0]  MASK_INIT = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 mode,
   input  logic [N-1:0]         w,
   input  logic                 load_mask,
   input  logic [(1<<N)-1:0]    mask_in,
`ifdef DOWN_SCAN_EN
   input  logic                 dir,
`endif
   output logic [(1<<N)-1:0]    y,
   output logic [N-1:0]         idx,
   output logic                 f,
   output logic                 wrap
);

   localparam int W  = 1 << N;
   localparam int CW = $clog2(DWELL) + 1;
   localparam logic [CW-1:0] DLAST   = CW'(DWELL - 1);
   localparam logic [N-1:0]  IDX_MAX = {N{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_t;

   state_t          state;
   state_t          next_state;
   logic [W-1:0]    mask;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_cur;
   logic            step;
   logic [N-1:0]    idx_step;
   logic            wrap_hit;

   // Next state from en/mode priority; dwell progress only survives uninterrupted SCAN
   always_comb begin
      next_state = S_IDLE;
      if (!en)
         next_state = S_IDLE;
      else if (!mode)
         next_state = S_DIRECT;
      else
         next_state = S_SCAN;

      cnt_cur = (state == S_SCAN) ? cnt : '0;
      step    = (cnt_cur == DLAST);

`ifdef DOWN_SCAN_EN
      idx_step = dir ? (idx - N'(1)) : (idx + N'(1));
      wrap_hit = dir ? (idx == '0) : (idx == IDX_MAX);
`else
      idx_step = idx + N'(1);
      wrap_hit = (idx == IDX_MAX);
`endif
   end

   // State, index, one-hot, dwell counter, wrap pulse and mask register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         mask  <= MASK_INIT;
         cnt   <= '0;
         idx   <= '0;
         y     <= '0;
         wrap  <= 1'b0;
      end else begin
         if (load_mask)
            mask <= mask_in;
         state <= next_state;
         case (next_state)
            S_DIRECT: begin
               idx  <= w;
               y    <= W'(1) << w;
               cnt  <= '0;
               wrap <= 1'b0;
            end
            S_SCAN: begin
               if (step) begin
                  idx  <= idx_step;
                  y    <= W'(1) << idx_step;
                  cnt  <= '0;
                  wrap <= wrap_hit;
               end else begin
                  y    <= W'(1) << idx;
                  cnt  <= cnt_cur + CW'(1);
                  wrap <= 1'b0;
               end
            end
            default: begin
               y    <= '0;
               cnt  <= '0;
               wrap <= 1'b0;
            end
         endcase
      end
   end

   // y and mask are registered together, so this AND-OR never sees a half-updated pair
   assign f = |(y & mask);

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - directed self-checking bench for scan_decoder
module tb_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        mode;
   logic [2:0]  w;
   logic        load_mask;
   logic [7:0]  mask_in;
`ifdef DOWN_SCAN_EN
   logic        dir;
`endif
   logic [7:0]  y1, y3;
   logic [2:0]  idx1, idx3;
   logic        f1, f3, wrap1, wrap3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   scan_decoder #(.N(3), .DWELL(1), .MASK_INIT(8'h00)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w),
      .load_mask(load_mask), .mask_in(mask_in),
`ifdef DOWN_SCAN_EN
      .dir(dir),
`endif
      .y(y1), .idx(idx1), .f(f1), .wrap(wrap1)
   );

   scan_decoder #(.N(3), .DWELL(3), .MASK_INIT(8'hA5)) dut3 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w),
      .load_mask(load_mask), .mask_in(mask_in),
`ifdef DOWN_SCAN_EN
      .dir(dir),
`endif
      .y(y3), .idx(idx3), .f(f3), .wrap(wrap3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; w = '0; load_mask = 1'b0; mask_in = '0;
`ifdef DOWN_SCAN_EN
      dir = 1'b0;
`endif
      #12;
      chk("reset_y",    32'(y1), 32'h0);
      chk("reset_idx",  32'(idx1), 32'h0);
      chk("reset_f",    32'(f1), 32'h0);
      chk("reset_wrap", 32'(wrap1), 32'h0);
      rst = 1'b0;

      // DIRECT w=0 with reset mask: only dut3 (A5) has bit 0 set
      en = 1'b1; mode = 1'b0; w = 3'd0;
      step();
      chk("maskinit_f_d1", 32'(f1), 32'h0);
      chk("maskinit_f_d3", 32'(f3), 32'h1);

      // mask 96, w=5 then w=4
      load_mask = 1'b1; mask_in = 8'h96; w = 3'd5;
      step();
      load_mask = 1'b0;
      chk("direct5_y",   32'(y1), 32'h20);
      chk("direct5_idx", 32'(idx1), 32'h5);
      chk("direct5_f",   32'(f1), 32'h0);
      w = 3'd4;
      step();
      chk("direct4_y", 32'(y1), 32'h10);
      chk("direct4_f", 32'(f1), 32'h1);

      // DIRECT jump 7 -> 0 never wraps
      w = 3'd7;
      step();
      w = 3'd0;
      step();
      chk("direct_nowrap_idx", 32'(idx1), 32'h0);
      chk("direct_nowrap",     32'(wrap1), 32'h0);

      // DIRECT w=6 then SCAN, DWELL=1: 6,7,0,1
      w = 3'd6;
      step();
      chk("scan_start_idx", 32'(idx1), 32'h6);
      mode = 1'b1;
      step();
      chk("scan_idx7",  32'(idx1), 32'h7);
      chk("scan_y7",    32'(y1), 32'h80);
      chk("scan_wrap7", 32'(wrap1), 32'h0);
      step();
      chk("scan_idx0",  32'(idx1), 32'h0);
      chk("scan_y0",    32'(y1), 32'h01);
      chk("scan_wrap0", 32'(wrap1), 32'h1);
      step();
      chk("scan_idx1",  32'(idx1), 32'h1);
      chk("scan_wrap1", 32'(wrap1), 32'h0);

      // async reset mid-scan, checked before any further edge
      #2 rst = 1'b1;
      #1;
      chk("async_y",    32'(y1), 32'h0);
      chk("async_idx",  32'(idx1), 32'h0);
      chk("async_f",    32'(f1), 32'h0);
      chk("async_wrap", 32'(wrap1), 32'h0);
      chk("async_idx3", 32'(idx3), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // mask back to MASK_INIT: w=1 hits bit 1 of 96 but not of 00
      mode = 1'b0; w = 3'd1;
      step();
      chk("mask_reset_f", 32'(f1), 32'h0);
      w = 3'd0;
      step();
      chk("d3_direct0_idx", 32'(idx3), 32'h0);

      // DWELL=3 scan from 0
      mode = 1'b1;
      step();
      chk("dw_e1_idx", 32'(idx3), 32'h0);
      chk("dw_e1_y",   32'(y3), 32'h01);
      step();
      chk("dw_e2_idx", 32'(idx3), 32'h0);
      step();
      chk("dw_e3_idx", 32'(idx3), 32'h1);
      chk("dw_e3_y",   32'(y3), 32'h02);
      step();
      step();
      chk("dw_e5_y",   32'(y3), 32'h02);
      step();
      chk("dw_e6_idx", 32'(idx3), 32'h2);
      for (int i = 0; i < 6; i++) step();
      chk("dw_e12_idx", 32'(idx3), 32'h4);

      // disable 5 cycles at idx 4, load mask 10 while idle
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load_mask = (i == 2);
         mask_in = 8'h10;
         step();
         chk("idle_y3",   32'(y3), 32'h0);
         chk("idle_idx3", 32'(idx3), 32'h4);
      end
      load_mask = 1'b0;
      chk("idle_f3", 32'(f3), 32'h0);
      en = 1'b1;
      step();
      chk("resume_e1_idx", 32'(idx3), 32'h4);
      chk("resume_e1_f",   32'(f3), 32'h1);
      step();
      chk("resume_e2_idx", 32'(idx3), 32'h4);
      step();
      chk("resume_e3_idx", 32'(idx3), 32'h5);
      chk("resume_e3_f",   32'(f3), 32'h0);

`ifdef DOWN_SCAN_EN
      // down-scan from 1: 0, 7, 6 with wrap at 7
      mode = 1'b0; w = 3'd1; dir = 1'b1;
      step();
      mode = 1'b1;
      step();
      chk("down_idx0",  32'(idx1), 32'h0);
      chk("down_wrap0", 32'(wrap1), 32'h0);
      step();
      chk("down_idx7",  32'(idx1), 32'h7);
      chk("down_wrap7", 32'(wrap1), 32'h1);
      step();
      chk("down_idx6",  32'(idx1), 32'h6);
      chk("down_wrap6", 32'(wrap1), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
